// File: rtl/spi_pkg.sv
// Shared types for the SPI register-bank peripheral: frame FSM states and read-source selection.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

    typedef enum logic [1:0] {SRC_REG, SRC_RO, SRC_ZERO} rd_src_e;

    // Where a read of `addr` takes its value from.
    function automatic rd_src_e rd_sel(input int addr, input int n_regs, input logic is_ro);
        if (addr >= n_regs) return SRC_ZERO;
        return is_ro ? SRC_RO : SRC_REG;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer for an asynchronous pin, with single-cycle rise/fall pulses.
// Latency: pulse visible 2 clk after the pin is first sampled; no backpressure.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= RST_VAL;
            sync   <= RST_VAL;
            sync_d <= RST_VAL;
        end else begin
            meta   <= d;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;
    assign fall = ~sync & sync_d;

endmodule

// File: rtl/spi_regbank_periph.sv
// SPI slave register bank: command byte {wr, addr} then auto-incrementing data bytes, all on iclk.
// Latency: register write commits 1 iclk after the last synced sclk rise; no backpressure (SPI master paces).
module spi_regbank_periph
    import spi_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 7,
    parameter int                N_REGS       = 66,
    parameter logic [N_REGS-1:0] RO_MASK      = '0,
    parameter int                INST_ADDR    = 2,
    parameter int                IDLE_TIMEOUT = 1024
) (
    input  logic                     iclk,
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     csn,
    input  logic                     serial_in,
    output logic                     serial_out,
    input  logic [N_REGS*DATA_W-1:0] ro_d,
    output logic [N_REGS*DATA_W-1:0] reg_q,
    output logic                     inst_strobe,
    output logic [DATA_W-1:0]        inst_code,
    output logic                     frame_err
);

    localparam int                BC_W       = $clog2(DATA_W);
    localparam int                TMO_W      = $clog2(IDLE_TIMEOUT);
    localparam int                CMD_WR_BIT = DATA_W - 1;
    localparam logic [BC_W-1:0]   BIT_LAST   = BC_W'(DATA_W - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(IDLE_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N_REGS - 1);

    state_e              state, state_nxt;
    logic                sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic                sin_meta, sin_s;
    logic [BC_W-1:0]     bit_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic                wr, wr_ok, commit, tmo_exp;
    logic                cmd_done, byte_done, frame_err_nxt;
    logic [DATA_W-1:0]   shift_in, shift_out, byte_in;
    logic [DATA_W-1:0]   regs [N_REGS];

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(iclk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_csn_sync (
        .clk(iclk), .rst(rst), .d(csn), .rise(csn_rise), .fall(csn_fall)
    );

    // Same 2-stage depth as the sclk path so data lines up with the rise pulse.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            sin_meta <= 1'b0;
            sin_s    <= 1'b0;
        end else begin
            sin_meta <= serial_in;
            sin_s    <= sin_meta;
        end
    end

    function automatic logic ro_at(input logic [ADDR_W-1:0] a);
        return (int'(a) < N_REGS) ? RO_MASK[a] : 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        case (rd_sel(int'(a), N_REGS, ro_at(a)))
            SRC_RO:  return ro_d[int'(a)*DATA_W +: DATA_W];
            SRC_REG: return regs[a];
            default: return '0;
        endcase
    endfunction

    assign byte_in  = {shift_in[DATA_W-2:0], sin_s};
    assign addr_nxt = (addr == ADDR_LAST) ? '0 : addr + 1'b1;
    assign wr_ok    = wr && (rd_sel(int'(addr), N_REGS, ro_at(addr)) == SRC_REG);
    assign tmo_exp  = (state != IDLE) && !sclk_rise && !sclk_fall && (tmo_cnt == TMO_LAST);

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        frame_err_nxt = 1'b0;
        cmd_done      = 1'b0;
        byte_done     = 1'b0;
        if (csn_rise) begin
            state_nxt     = IDLE;
            frame_err_nxt = (state != IDLE) && (bit_cnt != '0);
        end else if (csn_fall) begin
            state_nxt = CMD;
        end else if (tmo_exp) begin
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
        end else if (sclk_rise && bit_cnt == BIT_LAST) begin
            if (state == CMD) begin
                state_nxt = DATA;
                cmd_done  = 1'b1;
            end else if (state == DATA) begin
                byte_done = 1'b1;
            end
        end
    end

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            addr        <= '0;
            wr          <= 1'b0;
            shift_in    <= '0;
            shift_out   <= '0;
            serial_out  <= 1'b0;
            commit      <= 1'b0;
            inst_strobe <= 1'b0;
            inst_code   <= '0;
            frame_err   <= 1'b0;
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else begin
            frame_err   <= frame_err_nxt;
            inst_strobe <= 1'b0;
            commit      <= byte_done;
            if (state_nxt == IDLE || csn_fall) begin
                bit_cnt <= '0;
                tmo_cnt <= '0;
                if (csn_fall) serial_out <= 1'b0;
            end else begin
                tmo_cnt <= (sclk_rise || sclk_fall) ? '0 : tmo_cnt + 1'b1;
                if (sclk_rise) begin
                    shift_in <= byte_in;
                    bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                end
                if (sclk_fall) begin
                    serial_out <= (state == DATA) && shift_out[DATA_W-1];
                    shift_out  <= shift_out << 1;
                end
                if (cmd_done) begin
                    wr        <= byte_in[CMD_WR_BIT];
                    addr      <= byte_in[ADDR_W-1:0];
                    shift_out <= byte_in[CMD_WR_BIT] ? '0 : rd_val(byte_in[ADDR_W-1:0]);
                end
            end
            // A completed byte commits even if csn has already risen.
            if (commit) begin
                if (wr_ok) begin
                    regs[addr] <= shift_in;
                    if (int'(addr) == INST_ADDR) begin
                        inst_strobe <= 1'b1;
                        inst_code   <= shift_in;
                    end
                end
                addr <= addr_nxt;
                if (!wr) shift_out <= rd_val(addr_nxt);
            end
        end
    end

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg_q
        assign reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs[i];
    end

endmodule

// File: tb/tb_spi_regbank_periph.sv
// Bench for spi_regbank_periph: SPI master stimulus, reference register model, queue-based output monitor.
module tb_spi_regbank_periph;

    localparam int DW   = 8;
    localparam int NR   = 66;
    localparam int IT   = 1024;
    localparam int HALF = 5;
    localparam int VW   = NR * DW;
    localparam logic [NR-1:0] RO_M = (66'd1 << 60) | (66'd1 << 10);

    typedef logic [VW-1:0] vec_t;

    logic          iclk = 1'b0;
    logic          rst, sclk, csn, serial_in, serial_out, inst_strobe, frame_err;
    logic [VW-1:0] ro_d, reg_q;
    logic [DW-1:0] inst_code;

    spi_regbank_periph #(.RO_MASK(RO_M), .IDLE_TIMEOUT(IT)) dut (
        .iclk(iclk), .rst(rst), .sclk(sclk), .csn(csn), .serial_in(serial_in),
        .serial_out(serial_out), .ro_d(ro_d), .reg_q(reg_q),
        .inst_strobe(inst_strobe), .inst_code(inst_code), .frame_err(frame_err)
    );

    always #5 iclk = ~iclk;

    int          n_run = 0;
    int          n_fail = 0;
    logic [7:0]  mdl [NR];
    logic [NR-1:0] ro_m_v;
    logic [7:0]  exp_code;
    logic [7:0]  rd_q[$];
    logic [7:0]  inst_q[$];
    int          err_q[$];

    task automatic check(input string name, input vec_t act, input vec_t exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge iclk);
        #2;
    endtask

    function automatic logic [7:0] mdl_rd(input int a);
        if (a >= NR) return 8'h00;
        if (ro_m_v[a]) return ro_d[a*DW +: DW];
        return mdl[a];
    endfunction

    function automatic int nxt(input int a);
        return (a == NR - 1) ? 0 : (a + 1) % 128;
    endfunction

    function automatic vec_t exp_vec();
        vec_t v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = ro_m_v[i] ? 8'h00 : mdl[i];
        return v;
    endfunction

    task automatic mdl_wr(input int a, input logic [7:0] b);
        if (a < NR && !ro_m_v[a]) begin
            mdl[a] = b;
            if (a == 2) begin
                inst_q.push_back(b);
                exp_code = b;
            end
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            serial_in = b[7-i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        csn = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        csn = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // One complete frame; byte k of a write is dat[31-8k -: 8], reads clock out dat as filler.
    task automatic frame(input logic wr, input int a, input int n, input logic [31:0] dat);
        logic [7:0] b;
        int         ma;
        cs_low();
        spi_bits({wr, 7'(a)}, 8);
        ma = a;
        for (int k = 0; k < n; k++) begin
            b = dat[31-8*k -: 8];
            if (wr) mdl_wr(ma, b);
            else    rd_q.push_back(mdl_rd(ma));
            ma = nxt(ma);
            spi_bits(b, 8);
        end
        cs_high();
    endtask

    // Monitor: decodes the bus as seen at sclk rises and pops expected DUT responses.
    initial begin
        int         bits;
        logic [7:0] cmd, rb, e;
        logic       sclk_q;
        bits = 0; cmd = 8'h00; rb = 8'h00; sclk_q = 1'b0;
        forever begin
            @(negedge iclk);
            if (rst || csn) begin
                bits = 0;
            end else if (sclk && !sclk_q) begin
                if (bits < 8) begin
                    cmd = {cmd[6:0], serial_in};
                    check("sout_in_cmd", vec_t'(serial_out), vec_t'(0));
                end else begin
                    rb = {rb[6:0], serial_out};
                    if (bits % 8 == 7 && !cmd[7]) begin
                        check("rd_expected", vec_t'(rd_q.size() != 0), vec_t'(1));
                        if (rd_q.size() != 0) begin
                            e = rd_q.pop_front();
                            check("rd_byte", vec_t'(rb), vec_t'(e));
                        end
                    end
                end
                bits++;
            end
            sclk_q = sclk;
            if (inst_strobe) begin
                check("strobe_expected", vec_t'(inst_q.size() != 0), vec_t'(1));
                if (inst_q.size() != 0) begin
                    e = inst_q.pop_front();
                    check("strobe_code", vec_t'(inst_code), vec_t'(e));
                end
            end
            if (frame_err) begin
                check("err_expected", vec_t'(err_q.size() != 0), vec_t'(1));
                if (err_q.size() != 0) void'(err_q.pop_front());
            end
        end
    end

    initial begin
        logic wr;
        int   a, n;
        rst = 1'b1; sclk = 1'b0; csn = 1'b1; serial_in = 1'b0; ro_d = '0;
        ro_m_v = RO_M; exp_code = 8'h00;
        for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
        wait_clk(4);
        check("rst_reg_q", reg_q, vec_t'(0));
        check("rst_sout", vec_t'(serial_out), vec_t'(0));
        check("rst_strobe", vec_t'(inst_strobe), vec_t'(0));
        check("rst_code", vec_t'(inst_code), vec_t'(0));
        check("rst_err", vec_t'(frame_err), vec_t'(0));
        rst = 1'b0;
        wait_clk(4);

        frame(1'b1, 1, 2, 32'hA53C_0000);
        check("burst_regs", reg_q, exp_vec());
        check("burst_code", vec_t'(inst_code), vec_t'(exp_code));

        ro_d[60*DW +: DW] = 8'h5A;
        frame(1'b0, 60, 2, 32'h0);

        frame(1'b1, 65, 2, 32'h1122_0000);
        check("wrap_regs", reg_q, exp_vec());
        frame(1'b1, 60, 1, 32'hFF00_0000);
        check("ro_write_regs", reg_q, exp_vec());
        frame(1'b0, 60, 1, 32'h0);

        cs_low();
        spi_bits(8'h85, 8);
        err_q.push_back(1);
        spi_bits(8'hF0, 4);
        cs_high();
        check("abort_regs", reg_q, exp_vec());

        cs_low();
        err_q.push_back(1);
        spi_bits(8'h84, 3);
        cs_high();

        cs_low();
        spi_bits(8'h87, 8);
        mdl_wr(7, 8'h77);
        spi_bits(8'h77, 8);
        spi_bits(8'h0F, 4);
        err_q.push_back(1);
        wait_clk(IT + 100);
        spi_bits(8'h99, 8);
        cs_high();
        check("timeout_regs", reg_q, exp_vec());

        cs_low();
        spi_bits(8'h83, 8);
        spi_bits(8'hAB, 4);
        rst = 1'b1;
        wait_clk(2);
        for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
        exp_code = 8'h00;
        check("midrst_regs", reg_q, exp_vec());
        check("midrst_sout", vec_t'(serial_out), vec_t'(0));
        check("midrst_code", vec_t'(inst_code), vec_t'(exp_code));
        csn = 1'b1; sclk = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        frame(1'b1, 3, 1, 32'hAB00_0000);
        check("post_rst_regs", reg_q, exp_vec());
        frame(1'b0, 3, 1, 32'h0);

        for (int t = 0; t < 24; t++) begin
            ro_d[10*DW +: DW] = 8'($urandom);
            ro_d[60*DW +: DW] = 8'($urandom);
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, NR - 1));
            if (t % 6 == 0) a = int'($urandom_range(0, 2));
            n  = int'($urandom_range(1, 4));
            frame(wr, a, n, $urandom);
            check("rand_regs", reg_q, exp_vec());
            check("rand_code", vec_t'(inst_code), vec_t'(exp_code));
        end

        wait_clk(20);
        check("rd_q_drained", vec_t'(rd_q.size()), vec_t'(0));
        check("inst_q_drained", vec_t'(inst_q.size()), vec_t'(0));
        check("err_q_drained", vec_t'(err_q.size()), vec_t'(0));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
